// File: rtl/pss_pkg.sv
// Shared constants, FSM state type and helpers for the NR PSS generator.
package pss_pkg;

  localparam int         PSS_LEN        = 127;
  localparam logic [6:0] PSS_LFSR_INIT  = 7'b1110110;
  localparam int         PSS_SHIFT_STEP = 43;
  localparam logic [6:0] PSS_LAST_IDX   = 7'(PSS_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SKIP   = 2'd1,
    STREAM = 2'd2
  } pss_state_e;

  // Number of LFSR pre-roll steps for a given N_id_2 (cyclic shift 43*N_id_2).
  function automatic logic [6:0] pss_skip_count(input logic [1:0] n_id_2);
    logic [6:0] cnt;
    case (n_id_2)
      2'd1:    cnt = 7'(PSS_SHIFT_STEP);
      2'd2:    cnt = 7'(2 * PSS_SHIFT_STEP);
      default: cnt = 7'd0;
    endcase
    return cnt;
  endfunction

endpackage

// File: rtl/pss_lfsr.sv
// 7-bit Fibonacci LFSR for the PSS m-sequence: x(i+7) = x(i+4) ^ x(i).
// The register holds [x(i+6) .. x(i)], so the current sequence bit is bit 0.
module pss_lfsr
  import pss_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic load_i,
  input  logic adv_i,
  output logic x_o
);

  logic [6:0] state_q;
  logic [6:0] state_d;

  // Next state: load has priority over advance; otherwise hold.
  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = PSS_LFSR_INIT;
    end else if (adv_i) begin
      state_d = {state_q[4] ^ state_q[0], state_q[6:1]};
    end else begin
      state_d = state_q;
    end
  end

  // State register, reset to the sequence seed.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= PSS_LFSR_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  assign x_o = state_q[0];

endmodule

// File: rtl/pss_generator.sv
// NR PSS generator: emits the 127-sample BPSK sequence for N_id_2 as an
// AXI-stream of {im, re} samples with a backpressured output register.
// Optional macro PSS_GEN_TUSER_EN adds m_axis_out_tuser carrying sample index n.
module pss_generator
  import pss_pkg::*;
#(
  parameter int OUT_DW = 32,
  parameter int AMP    = 2**(OUT_DW/2-1)-1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [1:0]        N_id_2_i,
  input  logic              start_i,
  output logic [OUT_DW-1:0] m_axis_out_tdata,
  output logic              m_axis_out_tvalid,
  input  logic              m_axis_out_tready,
  output logic              m_axis_out_tlast,
`ifdef PSS_GEN_TUSER_EN
  output logic [6:0]        m_axis_out_tuser,
`endif
  output logic              busy_o
);

  localparam int                 HALF_DW = OUT_DW / 2;
  localparam logic [HALF_DW-1:0] RE_POS  = HALF_DW'(AMP);
  localparam logic [HALF_DW-1:0] RE_NEG  = HALF_DW'(-AMP);

  // BPSK mapping: x=0 -> +AMP, x=1 -> -AMP, imaginary part always zero.
  function automatic logic [OUT_DW-1:0] bpsk_sample(input logic x);
    return {{HALF_DW{1'b0}}, (x ? RE_NEG : RE_POS)};
  endfunction

  pss_state_e        state_q, state_d;
  logic [6:0]        skip_q, skip_d;
  logic [6:0]        n_q, n_d;
  logic [OUT_DW-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              busy_q, busy_d;

  logic              lfsr_load;
  logic              lfsr_adv;
  logic              lfsr_x;
  logic              start_ok;
  logic              handshake;

  assign start_ok  = start_i && (N_id_2_i != 2'd3);
  assign handshake = tvalid_q && m_axis_out_tready;

  pss_lfsr u_lfsr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (lfsr_load),
    .adv_i   (lfsr_adv),
    .x_o     (lfsr_x)
  );

  // FSM next state, LFSR control and output-register updates.
  // The LFSR always points at the next sample to be loaded into the output register.
  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    n_d       = n_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    busy_d    = busy_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          lfsr_load = 1'b1;
          busy_d    = 1'b1;
          n_d       = 7'd0;
          skip_d    = pss_skip_count(N_id_2_i);
          if (pss_skip_count(N_id_2_i) != 7'd0) begin
            state_d = SKIP;
          end else begin
            state_d = STREAM;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SKIP: begin
        lfsr_adv = 1'b1;
        skip_d   = skip_q - 7'd1;
        if (skip_q == 7'd1) begin
          state_d = STREAM;
        end else begin
          state_d = SKIP;
        end
      end
      STREAM: begin
        if (!tvalid_q) begin
          // First fill of the output register with sample 0.
          tdata_d  = bpsk_sample(lfsr_x);
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          lfsr_adv = 1'b1;
        end else if (handshake) begin
          if (n_q == PSS_LAST_IDX) begin
            tdata_d  = '0;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            busy_d   = 1'b0;
            n_d      = 7'd0;
            state_d  = IDLE;
          end else begin
            tdata_d  = bpsk_sample(lfsr_x);
            tlast_d  = (n_q == (PSS_LAST_IDX - 7'd1));
            n_d      = n_q + 7'd1;
            lfsr_adv = 1'b1;
          end
        end else begin
          // Stalled: hold tdata/tlast/tvalid.
          state_d = STREAM;
        end
      end
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        busy_d   = 1'b0;
      end
    endcase
  end

  // Registers for FSM, counters and the AXI-stream output stage.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      skip_q   <= 7'd0;
      n_q      <= 7'd0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      n_q      <= n_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      busy_q   <= busy_d;
    end
  end

  assign m_axis_out_tdata  = tdata_q;
  assign m_axis_out_tvalid = tvalid_q;
  assign m_axis_out_tlast  = tlast_q;
  assign busy_o            = busy_q;

`ifdef PSS_GEN_TUSER_EN
  // The handshake counter is exactly the index of the sample currently presented.
  assign m_axis_out_tuser = n_q;
`endif

endmodule

// File: tb/tb_pss_generator.sv
// Scoreboard bench for pss_generator: a golden m-sequence model pushes the
// expected frame at start; a negedge monitor pops and compares on handshakes.
module tb_pss_generator;

  localparam int OUT_DW = 32;
  localparam int AMP    = 32767;

  logic              clk     = 1'b0;
  logic              reset_i = 1'b1;
  logic              start_i = 1'b0;
  logic [1:0]        n_id    = 2'd0;
  logic              tready  = 1'b1;
  logic [OUT_DW-1:0] tdata;
  logic              tvalid;
  logic              tlast;
  logic              busy;
`ifdef PSS_GEN_TUSER_EN
  logic [6:0]        tuser;
`endif

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic [6:0]  idx;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          hs_cnt   = 0;
  int          re_sum   = 0;
  int          obs_re[8];
  int          gold_x[127];
  bit          rand_rdy = 1'b0;
  logic        stall_pending = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  int          first8[8] = '{AMP, -AMP, -AMP, AMP, -AMP, -AMP, -AMP, -AMP};

  pss_generator #(.OUT_DW(OUT_DW)) dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .N_id_2_i          (n_id),
    .start_i           (start_i),
    .m_axis_out_tdata  (tdata),
    .m_axis_out_tvalid (tvalid),
    .m_axis_out_tready (tready),
    .m_axis_out_tlast  (tlast),
`ifdef PSS_GEN_TUSER_EN
    .m_axis_out_tuser  (tuser),
`endif
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Golden model: recurrence x(i+7) = x(i+4) ^ x(i) from seed [x6..x0] = 1110110.
  task automatic build_gold();
    logic [6:0] seed;
    seed = 7'b1110110;
    for (int i = 0; i < 7; i++) gold_x[i] = int'(seed[i]);
    for (int i = 0; i < 120; i++) gold_x[i+7] = gold_x[i+4] ^ gold_x[i];
  endtask

  task automatic push_frame(input int nid);
    exp_t        e;
    int          m;
    logic [15:0] re16;
    for (int n = 0; n < 127; n++) begin
      m      = (n + 43 * nid) % 127;
      re16   = 16'((gold_x[m] != 0) ? -AMP : AMP);
      e.data = {16'h0000, re16};
      e.last = (n == 126);
      e.idx  = 7'(n);
      sb_q.push_back(e);
    end
  endtask

  // Random or always-on downstream ready, changed just after each active edge.
  always @(posedge clk) begin
    #1;
    tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Monitor: stability under stall and scoreboard comparison on handshake.
  always @(negedge clk) begin
    exp_t e;
    if (reset_i) begin
      sb_q.delete();
      stall_pending = 1'b0;
    end else begin
      if (stall_pending) begin
        chk("valid_hold", 64'(tvalid), 64'd1);
        chk("stall_data", 64'(tdata), 64'(prev_data));
        chk("stall_last", 64'(tlast), 64'(prev_last));
      end
      if (tvalid && tready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", 64'(sb_q.size()), 64'd1);
        end else begin
          e = sb_q.pop_front();
          chk("tdata", 64'(tdata), 64'(e.data));
          chk("tlast", 64'(tlast), 64'(e.last));
`ifdef PSS_GEN_TUSER_EN
          chk("tuser", 64'(tuser), 64'(e.idx));
`endif
          if (e.idx < 7'd8) obs_re[e.idx] = int'($signed(tdata[15:0]));
        end
        hs_cnt++;
        re_sum += int'($signed(tdata[15:0]));
        stall_pending = 1'b0;
      end else if (tvalid) begin
        stall_pending = 1'b1;
        prev_data     = tdata;
        prev_last     = tlast;
      end else begin
        stall_pending = 1'b0;
      end
    end
  end

  task automatic run_frame(input int nid, input int lat_exp, input int start_at, input bit chk8);
    int base_hs;
    int base_sum;
    int lat;
    int run;
    int w;
    push_frame(nid);
    base_hs  = hs_cnt;
    base_sum = re_sum;
    n_id     = 2'(nid);
    start_i  = 1'b1;
    @(posedge clk); #1;
    start_i  = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!tvalid && lat < 300);
    chk("latency", 64'(lat), 64'(lat_exp));
    run = 1;
    while (run < 2000) begin
      @(posedge clk); #1;
      if (!tvalid) break;
      run++;
      if (run == start_at) begin
        start_i = 1'b1;
        n_id    = 2'd1;
      end else begin
        start_i = 1'b0;
        n_id    = 2'(nid);
      end
    end
    start_i = 1'b0;
    n_id    = 2'(nid);
    if (!rand_rdy) chk("valid_run", 64'(run), 64'd127);
    w = 0;
    while ((sb_q.size() != 0 || busy) && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    chk("frame_drained", 64'(sb_q.size()), 64'd0);
    chk("busy_end", 64'(busy), 64'd0);
    chk("handshakes", 64'(hs_cnt - base_hs), 64'd127);
    chk("re_sum", 64'(re_sum - base_sum), 64'(-AMP));
    if (chk8) begin
      for (int i = 0; i < 8; i++) chk("first8_re", 64'(obs_re[i]), 64'(first8[i]));
    end
  endtask

  task automatic idle_check(input string tag);
    int v;
    int b;
    v = 0;
    b = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (tvalid) v++;
      if (busy) b++;
    end
    chk({tag, "_valid_cycles"}, 64'(v), 64'd0);
    chk({tag, "_busy_cycles"}, 64'(b), 64'd0);
  endtask

  initial begin
    int base;
    int w;
    build_gold();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_tdata", 64'(tdata), 64'd0);
    chk("rst_tvalid", 64'(tvalid), 64'd0);
    chk("rst_tlast", 64'(tlast), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset_i = 1'b0;
    @(posedge clk); #1;
    chk("idle_tvalid", 64'(tvalid), 64'd0);

    run_frame(0, 1, -1, 1'b1);
    run_frame(1, 44, -1, 1'b0);
    run_frame(2, 87, -1, 1'b0);

    rand_rdy = 1'b1;
    run_frame(2, 87, -1, 1'b0);
    rand_rdy = 1'b0;
    @(posedge clk); #1;

    run_frame(0, 1, 20, 1'b0);
    idle_check("mid_start");
    run_frame(0, 1, 127, 1'b0);
    idle_check("last_start");

    n_id    = 2'd3;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    n_id    = 2'd0;
    chk("bad_nid_busy", 64'(busy), 64'd0);
    idle_check("bad_nid");

    // Asynchronous reset in the middle of a frame.
    push_frame(0);
    base    = hs_cnt;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    w = 0;
    while ((hs_cnt - base) < 60 && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    chk("reached_sample_60", 64'(hs_cnt - base), 64'd60);
    #2 reset_i = 1'b1;
    #1;
    chk("async_rst_tdata", 64'(tdata), 64'd0);
    chk("async_rst_tvalid", 64'(tvalid), 64'd0);
    chk("async_rst_tlast", 64'(tlast), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
`ifdef PSS_GEN_TUSER_EN
    chk("async_rst_tuser", 64'(tuser), 64'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_tvalid", 64'(tvalid), 64'd0);
    run_frame(0, 1, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
